// File: rtl/div_seq_ctrl_if.sv
// Request/response bundle between the EX stage and the DIV/DIVU sequencer.
interface div_seq_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic              is_signed;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic              cancel;
    logic              stall_req;
    logic              ready;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;

    modport master (
        output start, is_signed, dividend, divisor, cancel,
        input  stall_req, ready, quotient, remainder
    );

    modport slave (
        input  start, is_signed, dividend, divisor, cancel,
        output stall_req, ready, quotient, remainder
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// 32-step restoring DIV/DIVU sequencer; stalls EX while busy, pulses ready.
// Optional macro DIV_ZERO_FAST_EN: divide by zero skips the BUSY phase.
module div_seq_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic          clk,
    input  logic          rst,
    div_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] pr;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvs;
    logic [DATA_W-1:0] dvd_raw;
    logic              q_neg;
    logic              r_neg;
    logic              dz;
    logic [DATA_W-1:0] q_r;
    logic [DATA_W-1:0] r_r;
    logic              rdy_r;

    logic              go;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_abs;
    logic [DATA_W-1:0] b_abs;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   trial;
    logic [DATA_W-1:0] pr_n;
    logic [DATA_W-1:0] quo_n;
    logic [DATA_W-1:0] q_fix;
    logic [DATA_W-1:0] r_fix;

    always_comb begin
        go     = (state == IDLE) && bus.start && !bus.cancel;
        a_neg  = bus.is_signed && bus.dividend[DATA_W-1];
        b_neg  = bus.is_signed && bus.divisor[DATA_W-1];
        a_abs  = a_neg ? -bus.dividend : bus.dividend;
        b_abs  = b_neg ? -bus.divisor : bus.divisor;
        rem_sh = {pr, quo[DATA_W-1]};
        trial  = rem_sh - {1'b0, dvs};
        if (!trial[DATA_W]) begin
            pr_n  = trial[DATA_W-1:0];
            quo_n = {quo[DATA_W-2:0], 1'b1};
        end else begin
            pr_n  = rem_sh[DATA_W-1:0];
            quo_n = {quo[DATA_W-2:0], 1'b0};
        end
        // Divide by zero bypasses the sign fix and returns the raw dividend.
        q_fix = dz ? '1 : (q_neg ? -quo_n : quo_n);
        r_fix = dz ? dvd_raw : (r_neg ? -pr_n : pr_n);
        bus.stall_req = !rst &&
                        (go || (state == BUSY && !bus.cancel));
    end

    assign bus.ready     = rdy_r;
    assign bus.quotient  = q_r;
    assign bus.remainder = r_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pr      <= '0;
            quo     <= '0;
            dvs     <= '0;
            dvd_raw <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            dz      <= 1'b0;
            q_r     <= '0;
            r_r     <= '0;
            rdy_r   <= 1'b0;
        end else begin
            rdy_r <= 1'b0;
            if (bus.cancel) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: if (bus.start) begin
                        dvs     <= b_abs;
                        quo     <= a_abs;
                        pr      <= '0;
                        cnt     <= '0;
                        dvd_raw <= bus.dividend;
                        q_neg   <= a_neg ^ b_neg;
                        r_neg   <= a_neg;
                        dz      <= (bus.divisor == '0);
`ifdef DIV_ZERO_FAST_EN
                        if (bus.divisor == '0) begin
                            state <= DONE;
                            rdy_r <= 1'b1;
                            q_r   <= '1;
                            r_r   <= bus.dividend;
                        end else begin
                            state <= BUSY;
                        end
`else
                        state <= BUSY;
`endif
                    end
                    BUSY: begin
                        pr  <= pr_n;
                        quo <= quo_n;
                        cnt <= cnt + CNT_W'(1);
                        // Final step: results land in the regs as DONE begins.
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            state <= DONE;
                            rdy_r <= 1'b1;
                            q_r   <= q_fix;
                            r_r   <= r_fix;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer for the DIV/DIVU datapath in the EX stage of the 5-stage MIPS pipeline.
- Accepts a divide request from EX and runs a 32-step restoring division.
- Raises a stall request to the pipeline hazard/stall logic while busy, then presents the quotient (to LO) and remainder (to HI) for one cycle.
- Honours a pipeline flush (cancel) at any point.

Parameters:
- DATA_W, 32, operand and result width
- CNT_W, 6, iteration counter width; must hold the value DATA_W

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  EX holds a DIV/DIVU; stays high while EX is held
- is_signed  in  1  1 = DIV, 0 = DIVU; sampled with start
- dividend  in  DATA_W  rs value; sampled with start
- divisor  in  DATA_W  rt value; sampled with start
- cancel  in  1  flush from exception/branch control
- stall_req  out  1  hold IF, ID and EX; bubble into MEM
- ready  out  1  one-cycle pulse; quotient and remainder valid
- quotient  out  DATA_W  to LO
- remainder  out  DATA_W  to HI

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, counter=0, quotient=0, remainder=0, ready=0. stall_req is combinational and forced to 0 while rst=1.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1 and cancel=0: latch |dividend| and |divisor| (plain values if is_signed=0), the sign of the quotient (sign(dividend) XOR sign(divisor), signed only) and the sign of the remainder (sign(dividend)). Clear counter and partial remainder, then go to BUSY.
  - Otherwise stay in IDLE.
- BUSY: each cycle performs one restoring step:
  - Shift {partial_rem, quo} left by 1.
  - Trial-subtract the divisor (DATA_W+1 bits).
  - If the result is non-negative, keep it and set the quotient LSB.
  - counter += 1. After counter reaches DATA_W (32 steps), go to DONE.
- DONE:
  - Apply sign fix (two's-complement negate where the latched sign is 1) and register quotient and remainder. ready=1 for exactly this cycle.
  - Next state is IDLE unconditionally; start is ignored in DONE.
- stall_req = (IDLE & start & ~cancel) | (BUSY & ~cancel). It is 0 in DONE, so the pipeline advances with ready=1.
- Latency: start seen in IDLE at cycle T; BUSY T+1..T+32; DONE/ready at T+33. stall_req is high T..T+32 (33 cycles).
- Back-to-back divides: a second DIV entering EX the cycle after DONE sees IDLE and starts normally.
- cancel=1 (any state): next state=IDLE, ready=0 next cycle, quotient and remainder keep their previous values. cancel has priority over start and over DONE completion.
- Divide by zero: result is defined as quotient=all-ones and remainder=dividend (unmodified input value), for both signed and unsigned. It is forced in DONE; sign fix is not applied.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0 (wraps, no trap).
- Outputs are held stable outside DONE; consumers qualify them with ready.

Optional Feature:
DIV_ZERO_FAST_EN
- Defined: in IDLE with start=1 and divisor==0, go directly to DONE. ready is high at T+1 and stall_req is high only in cycle T.
- Not defined: divide by zero runs the full 32 BUSY cycles (ready at T+33). The result is identical in both builds.

Test Plan:
- Unsigned: DIVU 100/7, start held until ready -> ready at T+33, quotient=14, remainder=2; stall_req high exactly 33 cycles.
- Signed: DIV -7/2 (0xFFFFFFF9/0x2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- Divide by zero: DIVU 0x1234/0 -> quotient=0xFFFFFFFF, remainder=0x1234. ready at T+33 without the macro, T+1 with DIV_ZERO_FAST_EN.
- Cancel: start at T, cancel=1 at T+10 -> state IDLE at T+11, stall_req=0 from T+10, no ready pulse, outputs unchanged. cancel together with start in IDLE -> no start, stall_req=0.
- Back-to-back: DIVU 9/3 then DIVU 10/4 with the second start the cycle after ready -> ready pulses 34 cycles apart, results (3,0) then (2,2).
- Reset mid-operation: rst=1 at T+5 of a divide -> next cycle IDLE, ready=0, quotient=remainder=0, stall_req=0 while rst=1; a new divide then completes normally.
